// File: rtl/alu_seq_exec.sv
// Multi-cycle execution unit. It takes one operation at a time through a valid/ready handshake.
// Arithmetic, logic, compare and branch ops finish in one cycle; shifts iterate one bit per cycle.
module alu_seq_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            branch_taken
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLT  = 4'b0001;
    localparam logic [3:0] OP_SLTU = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BLTU = 4'b1101;
    localparam logic [3:0] OP_BGEU = 4'b1110;
    localparam logic [3:0] OP_BGE  = 4'b1111;

    // state | meaning
    // IDLE  | waiting for an operation, in_ready high
    // SHIFT | iterating a shift one bit per cycle, r_cnt bits left
    // DONE  | result valid, waiting for out_ready
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_op;
    logic [XLEN-1:0]   r_sh;
    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              r_zero;
    logic              r_taken;

    logic              w_accept;
    logic              w_is_shift;
    logic              w_is_branch;
    logic [SHW-1:0]    w_k;
    logic              w_lt_s, w_lt_u, w_eq;
    logic [XLEN-1:0]   w_alu_res;
    logic              w_taken;
    logic [XLEN-1:0]   w_sh_next;

    assign in_ready     = (r_state == S_IDLE);
    assign out_valid    = (r_state == S_DONE);
    assign result       = r_result;
    assign zero         = r_zero;
    assign branch_taken = r_taken;

    assign w_accept    = in_valid && in_ready;
    assign w_k         = op_b[SHW-1:0];
    assign w_is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL) || (alu_control == OP_SRA);
    assign w_is_branch = (alu_control >= OP_BEQ);
    assign w_lt_s      = $signed(op_a) < $signed(op_b);
    assign w_lt_u      = op_a < op_b;
    assign w_eq        = op_a == op_b;

    // Shift codes pass op_a through; only used directly when the shift amount is zero.
    always_comb begin
        w_alu_res = '0;
        w_taken   = 1'b0;
        case (alu_control)
            OP_ADD:  w_alu_res = op_a + op_b;
            OP_SUB:  w_alu_res = op_a - op_b;
            OP_AND:  w_alu_res = op_a & op_b;
            OP_OR:   w_alu_res = op_a | op_b;
            OP_XOR:  w_alu_res = op_a ^ op_b;
            OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
            OP_SLL, OP_SRL, OP_SRA: w_alu_res = op_a;
            OP_BEQ:  w_taken = w_eq;
            OP_BNE:  w_taken = !w_eq;
            OP_BLT:  w_taken = w_lt_s;
            OP_BGE:  w_taken = !w_lt_s;
            OP_BLTU: w_taken = w_lt_u;
            OP_BGEU: w_taken = !w_lt_u;
            default: w_alu_res = '0;
        endcase
        if (w_is_branch) w_alu_res = {{(XLEN-1){1'b0}}, w_taken};
    end

    always_comb begin
        w_sh_next = {1'b0, r_sh[XLEN-1:1]};
        case (r_op)
            OP_SLL:  w_sh_next = {r_sh[XLEN-2:0], 1'b0};
            OP_SRA:  w_sh_next = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
            default: w_sh_next = {1'b0, r_sh[XLEN-1:1]};
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_is_shift && (w_k != '0)) ? S_SHIFT : S_DONE;
            S_SHIFT: if (r_cnt == SHW'(1)) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_taken  <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_op <= alu_control;
            if (w_is_shift && (w_k != '0)) begin
                r_sh  <= op_a;
                r_cnt <= w_k;
            end else begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_taken  <= w_taken;
            end
        end else if (r_state == S_SHIFT) begin
            r_sh  <= w_sh_next;
            r_cnt <= r_cnt - SHW'(1);
            if (r_cnt == SHW'(1)) begin
                r_result <= w_sh_next;
                r_zero   <= (w_sh_next == '0);
                r_taken  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed vector table, hand-written handshake/reset
// sequences, and randomized ops checked against an arithmetic reference model.
module tb_alu_seq_exec;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;

    int n_pass = 0;
    int n_total = 0;

    alu_seq_exec #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        taken;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: {taken, result} and latency straight from the operation definitions.
    function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        t;
        int          k;
        k = int'(b[4:0]);
        r = '0;
        t = 1'b0;
        case (c)
            4'd0:  r = a + b;
            4'd9:  r = a - b;
            4'd3:  r = a & b;
            4'd4:  r = a | b;
            4'd5:  r = a ^ b;
            4'd1:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd2:  r = (a < b) ? 32'd1 : 32'd0;
            4'd7:  r = a << k;
            4'd8:  r = a >> k;
            4'd6:  r = $signed(a) >>> k;
            4'd10: t = (a == b);
            4'd11: t = (a != b);
            4'd12: t = ($signed(a) < $signed(b));
            4'd15: t = ($signed(a) >= $signed(b));
            4'd13: t = (a < b);
            default: t = (a >= b);
        endcase
        if (c >= 4'd10) r = {31'd0, t};
        return {t, r};
    endfunction

    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        if ((c == 4'd6 || c == 4'd7 || c == 4'd8) && b[4:0] != 5'd0) return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Issues one op, scrambles the inputs while it runs, and returns the DONE outputs.
    // lat counts the accept cycle as 1; the result is left in DONE (not yet handed off).
    task automatic do_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic t, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        alu_control = c; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            alu_control = 4'($urandom); op_a = $urandom; op_b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        r = result; z = zero; t = branch_taken;
    endtask

    task automatic handoff(input string name, input logic [31:0] held);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
        chk({name, " in_ready after handoff"}, 32'(in_ready), 32'd1);
        chk({name, " result held"}, result, held);
    endtask

    task automatic run_checked(input string name, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] er, input logic et, input int el);
        logic [31:0] r;
        logic        z, t;
        int          lat;
        do_op(c, a, b, r, z, t, lat);
        chk({name, " result"}, r, er);
        chk({name, " zero"}, 32'(z), 32'(er == 32'd0));
        chk({name, " branch_taken"}, 32'(t), 32'(et));
        chk({name, " latency"}, 32'(lat), 32'(el));
        handoff(name, er);
    endtask

    initial begin
        logic [32:0] m;
        logic [3:0]  c;
        logic [31:0] a, b;

        tbl[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1};
        tbl[1]  = '{4'd9,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};
        tbl[2]  = '{4'd6,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 5};
        tbl[3]  = '{4'd7,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1};
        tbl[4]  = '{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1};
        tbl[5]  = '{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1};
        tbl[6]  = '{4'd14, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1};
        tbl[7]  = '{4'd7,  32'h00000001, 32'h00000008, 32'h00000100, 1'b0, 9};
        tbl[8]  = '{4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 32};
        tbl[9]  = '{4'd2,  32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1};
        tbl[10] = '{4'd1,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
        tbl[11] = '{4'd10, 32'h00000005, 32'h00000005, 32'h00000001, 1'b1, 1};
        tbl[12] = '{4'd11, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1};
        tbl[13] = '{4'd15, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1};
        tbl[14] = '{4'd8,  32'hF0000000, 32'h00000024, 32'h0F000000, 1'b0, 5};

        #12;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset zero", 32'(zero), 32'd1);
        chk("reset branch_taken", 32'(branch_taken), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i])
            run_checked($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].taken, tbl[i].lat);

        // DONE hold with out_ready low while in_valid pulses are offered
        begin
            logic [31:0] r;
            logic        z, t;
            int          lat;
            do_op(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, r, z, t, lat);
            chk("hold xor result", r, 32'hFF00FF00);
            chk("hold xor latency", 32'(lat), 32'd1);
            for (int i = 0; i < 6; i++) begin
                in_valid = i[0]; alu_control = 4'd0; op_a = 32'd1; op_b = 32'd1;
                @(posedge clk); #1;
                chk("hold result", result, 32'hFF00FF00);
                chk("hold out_valid", 32'(out_valid), 32'd1);
                chk("hold in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
            handoff("hold", 32'hFF00FF00);
        end

        // Reset mid-way through SRL by 31
        alu_control = 4'd8; op_a = 32'h80000000; op_b = 32'd31; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midshift in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst result", result, 32'd0);
        chk("rst zero", 32'(zero), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst idle", 32'(out_valid), 32'd0);
        run_checked("post-rst add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        for (int n = 0; n < 60; n++) begin
            c = 4'($urandom);
            a = (n % 4 == 0) ? 32'h80000000 : $urandom;
            b = (n % 5 == 0) ? a : $urandom;
            m = ref_op(c, a, b);
            run_checked($sformatf("rand%0d op%0d", n, c), c, a, b, m[31:0], m[32], ref_lat(c, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
